rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (regWrite/A3/wd) between two writeback sources.
- Primary source: in-order pipeline WB stage; it cannot be back-pressured except through p_stall.
- Secondary source: a multi-cycle unit (load/mul/div) that completes out of band, buffered in a small FIFO.
- Sits between the WB stage/long-latency unit and the RF write port. Provides a pending-write mask for hazard detection and a starvation-driven pipeline stall.

Parameters:
- XLEN, 32, data width.
- RFIDX_WIDTH, 5, register index width.
- RFREG_NUM, 32, number of architectural registers.
- FIFO_DEPTH, 2, secondary buffer entries (power of 2, ≥2).
- STARVE_LIMIT, 4, cycles a live FIFO head may wait before forcing a stall.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- p_valid  in  1  primary write request.
- p_rd  in  RFIDX_WIDTH  primary destination register.
- p_data  in  XLEN  primary write data.
- p_stall  out  1  stall request to pipeline; p_valid is ignored while high.
- s_valid  in  1  secondary write request.
- s_ready  out  1  secondary can accept (FIFO not full).
- s_rd  in  RFIDX_WIDTH  secondary destination register.
- s_data  in  XLEN  secondary write data.
- rf_we  out  1  RF regWrite.
- rf_a3  out  RFIDX_WIDTH  RF write index.
- rf_wd  out  XLEN  RF write data.
- pend_mask  out  RFREG_NUM  bit r set when a live FIFO entry targets xr.

Behaviour:
- Reset (rst=0, async): FIFO empty, all kill bits clear, starve counter 0, state NORMAL. rf_we=0, rf_a3=0, rf_wd=0, p_stall=0, pend_mask=0, s_ready=1.
- Output timing: rf_we/rf_a3/rf_wd are registered, so a grant in cycle N drives the RF write port in cycle N+1. pend_mask and s_ready are combinational from state.
- Push: on s_valid && s_ready, the entry {rd, data, kill=0} is enqueued. s_ready = (count < FIFO_DEPTH); a pop in the same cycle does not raise s_ready. s_rd=0 is enqueued with kill=1.
- Effective primary request: p_valid && !p_stall && p_rd != 0. p_rd=0 never consumes the port.
- State NORMAL:
  - Effective primary request granted → rf_we=1 with p_rd/p_data.
  - Otherwise, a live (unkilled) FIFO head is granted and popped.
  - A killed head is popped with no write in any cycle, independent of the primary grant.
  - Starve counter increments each cycle a live head is present and not granted; it clears on head grant or when the FIFO empties.
  - When counter == STARVE_LIMIT-1 and the head is still not granted → next state STALL.
- State STALL:
  - p_stall=1; primary is ignored.
  - Live head is granted and popped; counter cleared; next state NORMAL. p_stall is high for exactly one cycle.
  - If the head became killed or the FIFO emptied, nothing is written and the state still returns to NORMAL.
- WAW kill: when the primary is granted with rd=r, every FIFO entry with rd==r gets kill=1 in the same cycle. The primary is younger in program order, so the older buffered result is stale. A push in the same cycle with s_rd==r is not killed, because it is younger.
- pend_mask: OR over live entries of the one-hot rd. Bit 0 is always 0.
- Simultaneous push into an empty FIFO and no primary: the entry is not granted until the next cycle (no bypass).
- Wrap-around: read/write pointers are RFIDX-independent, mod FIFO_DEPTH; count is tracked separately to distinguish full from empty.
- Reset mid-operation: FIFO contents are discarded, and any rf_we in flight drops to 0 immediately.

Decomposition:
- Shared package/Define additions: XLEN, RFIDX_WIDTH, RFREG_NUM (existing); ARB_FIFO_DEPTH, ARB_STARVE_LIMIT; state encoding ARB_NORMAL=1'b0, ARB_STALL=1'b1.
- One sub-module, wb_kill_fifo:
  - Holds the storage, kill bits, pointers, count and pend_mask generation.
  - Has a kill_en/kill_rd port.
  - The top level holds the FSM, starve counter and output registers.

Test Plan:
- Reset/idle: hold rst=0 with random inputs → rf_we=0, pend_mask=0, s_ready=1. Release → outputs stay 0 with no requests.
- Primary only: p_valid, p_rd=5, p_data=32'hDEADBEEF in cycle N → rf_we=1, rf_a3=5, rf_wd=DEADBEEF in N+1. p_rd=0 → rf_we stays 0.
- Buffering/full:
  - Push s_rd=3/4 with data 11/22 while the primary is busy → s_ready=0 after 2 pushes; pend_mask=0x18.
  - Drop the primary → x3 is written, then x4, in order.
- Starvation: FIFO holds x7 while the primary is valid every cycle with p_rd=9 → p_stall=1 in exactly one cycle after 4 waiting cycles, x7 is written the following cycle, and the primary resumes.
- WAW kill:
  - FIFO holds x6=0xAA; primary writes x6=0xBB → pend_mask bit6 clears and the killed entry pops with no write. The final RF write sequence contains only x6=0xBB.
  - Same-cycle push s_rd=6 is kept.
- Async reset mid-burst: assert rst between clock edges with the FIFO full → rf_we=0 immediately, s_ready=1, and no stale write after release.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, defaults and FSM encoding for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;
    localparam int XLEN             = 32;
    localparam int RFIDX_WIDTH      = 5;
    localparam int RFREG_NUM        = 32;
    localparam int ARB_FIFO_DEPTH   = 2;
    localparam int ARB_STARVE_LIMIT = 4;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_STALL  = 1'b1
    } arb_state_e;
endpackage

// File: rtl/wb_kill_fifo.sv
// Small FIFO for out-of-band writebacks; entries can be killed in place when a
// younger primary write targets the same register, and live entries form pend_mask.
module wb_kill_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DW    = XLEN,
    parameter int IW    = RFIDX_WIDTH,
    parameter int NREG  = RFREG_NUM,
    parameter int DEPTH = ARB_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [IW-1:0]   push_rd,
    input  logic [DW-1:0]   push_data,
    input  logic            pop,
    input  logic            kill_en,
    input  logic [IW-1:0]   kill_rd,
    output logic            ready,
    output logic            head_valid,
    output logic            head_kill,
    output logic [IW-1:0]   head_rd,
    output logic [DW-1:0]   head_data,
    output logic [NREG-1:0] pend_mask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] kill_reg, kill_next;
    logic [IW-1:0]   rd_mem   [DEPTH];
    logic [DW-1:0]   data_mem [DEPTH];
    logic [NREG-1:0] entry_mask [DEPTH];
    logic            do_push, do_pop;

    // ready reflects the pre-pop count, so a same-cycle pop never frees a slot early
    assign ready      = (count_reg < CW'(DEPTH));
    assign head_valid = (count_reg != '0);
    assign do_push    = push && ready;
    assign do_pop     = pop && head_valid;
    assign head_kill  = kill_reg[rd_ptr_reg];
    assign head_rd    = rd_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wr_ptr_reg]   <= push_rd;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        valid_next = valid_reg;
        kill_next  = kill_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && valid_reg[i] && (rd_mem[i] == kill_rd))
                kill_next[i] = 1'b1;
            if (do_pop && (rd_ptr_reg == PW'(i)))
                valid_next[i] = 1'b0;
            // the pushed entry is younger than the primary write, so it is never killed by it
            if (do_push && (wr_ptr_reg == PW'(i))) begin
                valid_next[i] = 1'b1;
                kill_next[i]  = (push_rd == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
            kill_reg   <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
            valid_reg <= valid_next;
            kill_reg  <= kill_next;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign entry_mask[gi] = (valid_reg[gi] && !kill_reg[gi]) ? (NREG'(1) << rd_mem[gi]) : '0;
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            pend_mask = pend_mask | entry_mask[i];
        pend_mask[0] = 1'b0;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single RF write port between the WB stage (priority) and the
// buffered long-latency unit, forcing a one-cycle pipeline stall on starvation.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int XLEN_P       = XLEN,
    parameter int IDX_W        = RFIDX_WIDTH,
    parameter int REG_NUM      = RFREG_NUM,
    parameter int FIFO_DEPTH   = ARB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p_valid,
    input  logic [IDX_W-1:0]   p_rd,
    input  logic [XLEN_P-1:0]  p_data,
    output logic               p_stall,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [IDX_W-1:0]   s_rd,
    input  logic [XLEN_P-1:0]  s_data,
    output logic               rf_we,
    output logic [IDX_W-1:0]   rf_a3,
    output logic [XLEN_P-1:0]  rf_wd,
    output logic [REG_NUM-1:0] pend_mask
);
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    arb_state_e        state_reg;
    logic [SW-1:0]     starve_reg;
    logic              p_stall_reg, rf_we_reg;
    logic [IDX_W-1:0]  rf_a3_reg;
    logic [XLEN_P-1:0] rf_wd_reg;
    logic              head_valid, head_kill, head_live;
    logic [IDX_W-1:0]  head_rd;
    logic [XLEN_P-1:0] head_data;
    logic              p_grant, s_grant, pop;

    // in STALL the primary is masked, so the head wins whenever it is live
    assign p_grant   = (state_reg == ARB_NORMAL) && p_valid && (p_rd != '0);
    assign head_live = head_valid && !head_kill;
    assign s_grant   = head_live && !p_grant;
    assign pop       = s_grant || (head_valid && head_kill);

    wb_kill_fifo #(
        .DW(XLEN_P), .IW(IDX_W), .NREG(REG_NUM), .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid),
        .push_rd   (s_rd),
        .push_data (s_data),
        .pop       (pop),
        .kill_en   (p_grant),
        .kill_rd   (p_rd),
        .ready     (s_ready),
        .head_valid(head_valid),
        .head_kill (head_kill),
        .head_rd   (head_rd),
        .head_data (head_data),
        .pend_mask (pend_mask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ARB_NORMAL;
            starve_reg  <= '0;
            p_stall_reg <= 1'b0;
            rf_we_reg   <= 1'b0;
            rf_a3_reg   <= '0;
            rf_wd_reg   <= '0;
        end else begin
            rf_we_reg <= p_grant || s_grant;
            if (p_grant) begin
                rf_a3_reg <= p_rd;
                rf_wd_reg <= p_data;
            end else if (s_grant) begin
                rf_a3_reg <= head_rd;
                rf_wd_reg <= head_data;
            end
            case (state_reg)
                ARB_NORMAL: begin
                    if (head_live && !s_grant) begin
                        if (starve_reg == SW'(STARVE_LIMIT - 1)) begin
                            state_reg   <= ARB_STALL;
                            p_stall_reg <= 1'b1;
                            starve_reg  <= '0;
                        end else begin
                            starve_reg <= starve_reg + SW'(1);
                        end
                    end else begin
                        starve_reg <= '0;
                    end
                end
                default: begin
                    state_reg   <= ARB_NORMAL;
                    p_stall_reg <= 1'b0;
                    starve_reg  <= '0;
                end
            endcase
        end
    end

    assign p_stall = p_stall_reg;
    assign rf_we   = rf_we_reg;
    assign rf_a3   = rf_a3_reg;
    assign rf_wd   = rf_wd_reg;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter: one task per scenario.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_valid, s_valid;
    logic [4:0]  p_rd, s_rd;
    logic [31:0] p_data, s_data;
    logic        p_stall, s_ready, rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [36:0] wlog [$];

    rf_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_stall(p_stall),
        .s_valid(s_valid), .s_ready(s_ready), .s_rd(s_rd), .s_data(s_data),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst && rf_we) wlog.push_back({rf_a3, rf_wd});

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid = 1'b0; p_rd = '0; p_data = '0;
        s_valid = 1'b0; s_rd = '0; s_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p_valid = 1'($urandom); p_rd = 5'($urandom); p_data = $urandom;
            s_valid = 1'($urandom); s_rd = 5'($urandom); s_data = $urandom;
            cyc();
            n_cmp++;
            if ({rf_we, p_stall, s_ready, pend_mask, rf_a3, rf_wd} !== {1'b0, 1'b0, 1'b1, 32'h0, 5'd0, 32'h0}) begin
                n_bad++;
                $display("FAIL reset_hold: got we/stall/ready/mask/a3/wd=%b/%b/%b/%h/%0d/%h required 0/0/1/0/0/0",
                         rf_we, p_stall, s_ready, pend_mask, rf_a3, rf_wd);
            end
        end
        idle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if ({rf_we, p_stall, s_ready, pend_mask} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
                n_bad++;
                $display("FAIL reset_idle: got we/stall/ready/mask=%b/%b/%b/%h required 0/0/1/0",
                         rf_we, p_stall, s_ready, pend_mask);
            end
        end
    endtask

    task automatic test_primary();
        p_valid = 1'b1; p_rd = 5'd5; p_data = 32'hDEADBEEF;
        cyc();
        n_cmp++;
        if ({rf_we, rf_a3, rf_wd} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL prim_write: got we/a3/wd=%b/%0d/%h required 1/5/deadbeef", rf_we, rf_a3, rf_wd);
        end
        p_rd = 5'd0; p_data = 32'h0000_0123;
        cyc();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL prim_x0: got rf_we=%b required 0", rf_we);
        end
        p_rd = 5'd1; p_data = 32'h1;
        cyc();
        p_rd = 5'd2; p_data = 32'h2;
        cyc();
        n_cmp++;
        if ({rf_we, rf_a3, rf_wd} !== {1'b1, 5'd2, 32'h2}) begin
            n_bad++;
            $display("FAIL prim_b2b: got we/a3/wd=%b/%0d/%h required 1/2/2", rf_we, rf_a3, rf_wd);
        end
        idle();
        cyc();
    endtask

    task automatic test_buffer_full();
        p_valid = 1'b1; p_rd = 5'd10; p_data = 32'h1;
        s_valid = 1'b1; s_rd = 5'd3; s_data = 32'd11;
        cyc();
        s_rd = 5'd4; s_data = 32'd22;
        cyc();
        n_cmp++;
        if ({s_ready, pend_mask} !== {1'b0, 32'h18}) begin
            n_bad++;
            $display("FAIL buf_full: got ready/mask=%b/%h required 0/00000018", s_ready, pend_mask);
        end
        idle();
        cyc();
        n_cmp++;
        if ({rf_we, rf_a3, rf_wd, s_ready, pend_mask} !== {1'b1, 5'd3, 32'd11, 1'b1, 32'h10}) begin
            n_bad++;
            $display("FAIL buf_drain1: got we/a3/wd/ready/mask=%b/%0d/%0d/%b/%h required 1/3/11/1/00000010",
                     rf_we, rf_a3, rf_wd, s_ready, pend_mask);
        end
        cyc();
        n_cmp++;
        if ({rf_we, rf_a3, rf_wd, pend_mask} !== {1'b1, 5'd4, 32'd22, 32'h0}) begin
            n_bad++;
            $display("FAIL buf_drain2: got we/a3/wd/mask=%b/%0d/%0d/%h required 1/4/22/0",
                     rf_we, rf_a3, rf_wd, pend_mask);
        end
        cyc();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_bad++;
            $display("FAIL buf_quiet: got rf_we=%b required 0", rf_we);
        end
    endtask

    task automatic test_starvation();
        int stalls = 0;
        p_valid = 1'b1; p_rd = 5'd9; p_data = 32'h99;
        s_valid = 1'b1; s_rd = 5'd7; s_data = 32'd77;
        cyc();
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (p_stall === 1'b1) stalls++;
            n_cmp++;
            if ({p_stall, rf_we, rf_a3} !== {(i == 3), 1'b1, 5'd9}) begin
                n_bad++;
                $display("FAIL starve_wait%0d: got stall/we/a3=%b/%b/%0d required %b/1/9",
                         i, p_stall, rf_we, rf_a3, (i == 3));
            end
        end
        cyc();
        if (p_stall === 1'b1) stalls++;
        n_cmp++;
        if ({p_stall, rf_we, rf_a3, rf_wd} !== {1'b0, 1'b1, 5'd7, 32'd77}) begin
            n_bad++;
            $display("FAIL starve_grant: got stall/we/a3/wd=%b/%b/%0d/%0d required 0/1/7/77",
                     p_stall, rf_we, rf_a3, rf_wd);
        end
        cyc();
        n_cmp++;
        if ({stalls, rf_we, rf_a3} !== {32'd1, 1'b1, 5'd9}) begin
            n_bad++;
            $display("FAIL starve_resume: got stalls/we/a3=%0d/%b/%0d required 1/1/9", stalls, rf_we, rf_a3);
        end
        idle();
        cyc();
    endtask

    task automatic test_waw_kill();
        wlog.delete();
        s_valid = 1'b1; s_rd = 5'd6; s_data = 32'hAA;
        cyc();
        s_valid = 1'b0;
        n_cmp++;
        if (pend_mask !== 32'h40) begin
            n_bad++;
            $display("FAIL kill_pend: got mask=%h required 00000040", pend_mask);
        end
        p_valid = 1'b1; p_rd = 5'd6; p_data = 32'hBB;
        cyc();
        p_valid = 1'b0;
        n_cmp++;
        if ({pend_mask, rf_we, rf_a3, rf_wd} !== {32'h0, 1'b1, 5'd6, 32'hBB}) begin
            n_bad++;
            $display("FAIL kill_clear: got mask/we/a3/wd=%h/%b/%0d/%h required 0/1/6/bb",
                     pend_mask, rf_we, rf_a3, rf_wd);
        end
        cyc();
        cyc();
        n_cmp++;
        if ({wlog.size(), s_ready} !== {32'd1, 1'b1} || wlog[0] !== {5'd6, 32'hBB}) begin
            n_bad++;
            $display("FAIL kill_seq: got writes=%0d first=%h ready=%b required 1 write of 6/bb, ready 1",
                     wlog.size(), (wlog.size() > 0) ? wlog[0] : 37'h0, s_ready);
        end
        // older x6 is killed by the primary; a same-cycle push to x6 survives
        s_valid = 1'b1; s_rd = 5'd6; s_data = 32'hAA;
        cyc();
        p_valid = 1'b1; p_rd = 5'd6; p_data = 32'hDD;
        s_rd = 5'd6; s_data = 32'hCC;
        cyc();
        idle();
        n_cmp++;
        if ({pend_mask, rf_we, rf_a3, rf_wd} !== {32'h40, 1'b1, 5'd6, 32'hDD}) begin
            n_bad++;
            $display("FAIL kill_same_cyc: got mask/we/a3/wd=%h/%b/%0d/%h required 00000040/1/6/dd",
                     pend_mask, rf_we, rf_a3, rf_wd);
        end
        cyc();
        n_cmp++;
        if ({rf_we, pend_mask} !== {1'b0, 32'h40}) begin
            n_bad++;
            $display("FAIL kill_pop_nowrite: got we/mask=%b/%h required 0/00000040", rf_we, pend_mask);
        end
        cyc();
        n_cmp++;
        if ({rf_we, rf_a3, rf_wd, pend_mask} !== {1'b1, 5'd6, 32'hCC, 32'h0}) begin
            n_bad++;
            $display("FAIL kill_kept: got we/a3/wd/mask=%b/%0d/%h/%h required 1/6/cc/0",
                     rf_we, rf_a3, rf_wd, pend_mask);
        end
        s_valid = 1'b1; s_rd = 5'd0; s_data = 32'h55;
        cyc();
        s_valid = 1'b0;
        n_cmp++;
        if ({pend_mask, rf_we} !== {32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL x0_push: got mask/we=%h/%b required 0/0", pend_mask, rf_we);
        end
        cyc();
        cyc();
        n_cmp++;
        if ({rf_we, s_ready} !== {1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL x0_drop: got we/ready=%b/%b required 0/1", rf_we, s_ready);
        end
    endtask

    task automatic test_async_reset();
        p_valid = 1'b1; p_rd = 5'd12; p_data = 32'h5;
        s_valid = 1'b1; s_rd = 5'd3; s_data = 32'd33;
        cyc();
        s_rd = 5'd4; s_data = 32'd44;
        cyc();
        n_cmp++;
        if ({s_ready, rf_we} !== {1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL arst_pre: got ready/we=%b/%b required 0/1", s_ready, rf_we);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({rf_we, s_ready, pend_mask, p_stall} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL arst_now: got we/ready/mask/stall=%b/%b/%h/%b required 0/1/0/0",
                     rf_we, s_ready, pend_mask, p_stall);
        end
        idle();
        wlog.delete();
        cyc();
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        n_cmp++;
        if ({wlog.size(), rf_we, pend_mask, s_ready} !== {32'd0, 1'b0, 32'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL arst_after: got writes/we/mask/ready=%0d/%b/%h/%b required 0/0/0/1",
                     wlog.size(), rf_we, pend_mask, s_ready);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_primary();
        test_buffer_full();
        test_starvation();
        test_waw_kill();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
